// File: rtl/ahblite_iic_target_pkg.sv
// ahblite_iic_target_pkg: FSM state encoding and register map constants for the I2C target
package ahblite_iic_target_pkg;
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_BYTE  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_BYTE  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;
  // word index of STATUS (byte offset 0x40)
  localparam logic [4:0] STATUS_IDX = 5'h10;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_RXFLAG = 1;
endpackage

// File: rtl/ahblite_iic_target_pin_sync.sv
// iic_pin_sync: SCL/SDA synchroniser with SCL edge and START/STOP pulse detection
module iic_pin_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);
  // bits [1:0] synchronise, bit [2] holds the previous synchronised value
  logic [2:0] r_scl, r_sda;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_scl <= '1;
      r_sda <= '1;
    end else begin
      r_scl <= {r_scl[1:0], i_scl};
      r_sda <= {r_sda[1:0], i_sda};
    end
  assign o_sda      = r_sda[1];
  assign o_scl_rise = r_scl[1] & ~r_scl[2];
  assign o_scl_fall = ~r_scl[1] & r_scl[2];
  assign o_start    = r_scl[1] & r_scl[2] & r_sda[2] & ~r_sda[1];
  assign o_stop     = r_scl[1] & r_scl[2] & ~r_sda[2] & r_sda[1];
endmodule

// File: rtl/ahblite_iic_target.sv
// ahblite_iic_target: I2C target exposing a byte register bank to an I2C master and to AHB-lite
module ahblite_iic_target
  import ahblite_iic_target_pkg::*;
#(
  parameter logic [6:0] IIC_ADDR = 7'h42,
  parameter int NREG = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  input  logic        IIC_SCL,
  inout  wire         IIC_SDA
);
  localparam int PW = $clog2(NREG);
  logic [7:0] r_bank [NREG];
  logic [PW-1:0] r_ptr;
  logic [2:0] r_state, r_bitcnt;
  logic [7:0] r_shift;
  logic r_rw, r_first, r_got, r_rxflag, r_sda_low, r_ahb_wr;
  logic [4:0] r_ahb_addr;
  logic w_sda, w_rise, w_fall, w_start, w_stop, w_last, w_ahb_bank, w_unused;
  logic [7:0] w_byte;
  logic [31:0] w_status;
  iic_pin_sync u_sync (
    .i_clk(HCLK),
    .i_rst(HRESET),
    .i_scl(IIC_SCL),
    .i_sda(IIC_SDA),
    .o_sda(w_sda),
    .o_scl_rise(w_rise),
    .o_scl_fall(w_fall),
    .o_start(w_start),
    .o_stop(w_stop)
  );
  assign IIC_SDA    = r_sda_low ? 1'b0 : 1'bz;
  assign HREADYOUT  = 1'b1;
  assign HRESP      = 1'b0;
  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_last     = w_rise & (r_bitcnt == 3'd7);
  assign w_ahb_bank = r_ahb_addr < 5'(NREG);
  assign w_unused   = ^{HADDR[31:7], HADDR[1:0], HTRANS[0], HSIZE, HPROT, HWDATA[31:8]};
  always_comb begin
    w_status = '0;
    w_status[STAT_BUSY] = r_state != S_IDLE;
    w_status[STAT_RXFLAG] = r_rxflag;
  end
  assign HRDATA = w_ahb_bank ? {24'b0, r_bank[r_ahb_addr[PW-1:0]]} :
                  (r_ahb_addr == STATUS_IDX ? w_status : '0);
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < NREG; i++) r_bank[i] <= '0;
      r_ptr <= '0;
      r_state <= S_IDLE;
      r_bitcnt <= '0;
      r_shift <= '0;
      r_rw <= 1'b0;
      r_first <= 1'b0;
      r_got <= 1'b0;
      r_rxflag <= 1'b0;
      r_sda_low <= 1'b0;
      r_ahb_addr <= '0;
      r_ahb_wr <= 1'b0;
    end else begin
      r_ahb_wr <= HSEL & HREADY & HTRANS[1] & HWRITE;
      if (HSEL & HREADY & HTRANS[1]) r_ahb_addr <= HADDR[6:2];
      if (r_ahb_wr & w_ahb_bank) r_bank[r_ahb_addr[PW-1:0]] <= HWDATA[7:0];
      if (r_ahb_wr & (r_ahb_addr == STATUS_IDX) & HWDATA[STAT_RXFLAG]) r_rxflag <= 1'b0;
      // I2C updates follow the AHB ones so a same-cycle I2C bank write or RXFLAG set wins
      if (w_start) begin
        r_state <= S_ADDR;
        r_bitcnt <= '0;
        r_sda_low <= 1'b0;
      end else if (w_stop) begin
        r_state <= S_IDLE;
        r_sda_low <= 1'b0;
        r_got <= 1'b0;
        if (r_got) r_rxflag <= 1'b1;
      end else begin
        if (w_rise & ((r_state == S_ADDR) | (r_state == S_WR_BYTE) | (r_state == S_RD_BYTE))) begin
          r_bitcnt <= r_bitcnt + 3'd1;
          r_shift <= w_byte;
        end
        case (r_state)
          S_ADDR: if (w_last) begin
            r_state <= (w_byte[7:1] == IIC_ADDR) ? S_ADDR_ACK : S_IDLE;
            r_rw <= w_byte[0];
            r_first <= 1'b1;
            if (w_byte[0]) r_shift <= r_bank[r_ptr];
          end
          // first fall starts the ACK low, second fall ends it and presents the next bit
          S_ADDR_ACK, S_WR_ACK: if (w_fall) begin
            if (!r_sda_low) r_sda_low <= 1'b1;
            else begin
              r_state <= ((r_state == S_ADDR_ACK) & r_rw) ? S_RD_BYTE : S_WR_BYTE;
              r_sda_low <= (r_state == S_ADDR_ACK) & r_rw & ~r_shift[7];
            end
          end
          S_WR_BYTE: if (w_last) begin
            r_state <= S_WR_ACK;
            r_first <= 1'b0;
            if (r_first) r_ptr <= w_byte[PW-1:0];
            else begin
              r_bank[r_ptr] <= w_byte;
              r_ptr <= r_ptr + PW'(1);
              r_got <= 1'b1;
            end
          end
          S_RD_BYTE: begin
            if (w_fall) r_sda_low <= ~r_shift[7];
            if (w_last) begin
              r_state <= S_RD_ACK;
              r_ptr <= r_ptr + PW'(1);
            end
          end
          S_RD_ACK: begin
            if (w_fall) r_sda_low <= 1'b0;
            if (w_rise) begin
              r_state <= w_sda ? S_IDLE : S_RD_BYTE;
              r_shift <= r_bank[r_ptr];
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ahblite_iic_target.sv
// tb_ahblite_iic_target: bit-level I2C master and AHB driver checked against a byte-level register model
module tb_ahblite_iic_target;
  logic clk = 1'b0, rst = 1'b1;
  logic hsel = 1'b0, hwrite = 1'b0, hready = 1'b1;
  logic [1:0] htrans = 2'b00;
  logic [31:0] haddr = '0, hwdata = '0, hrdata, d;
  logic hreadyout, hresp, ack;
  logic scl = 1'b1, m_sda = 1'b1;
  wire sda;
  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);
  int n_tests = 0, n_fail = 0, q = 2;
  logic [7:0] m_bank [8];
  logic [7:0] tx [4];
  int m_ptr = 0;
  logic m_rx = 1'b0, m_got = 1'b0;

  always #5 clk = ~clk;

  ahblite_iic_target dut (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(3'b010), .HPROT(4'b0011), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout), .HRDATA(hrdata), .HRESP(hresp), .IIC_SCL(scl), .IIC_SDA(sda)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ahb_wr(input logic [31:0] a, input logic [31:0] v);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a; tick(1);
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = v; tick(1);
  endtask

  task automatic ahb_rd(input logic [31:0] a, output logic [31:0] v);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = a; tick(1);
    hsel = 1'b0; htrans = 2'b00; v = hrdata;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 8; i++) m_bank[i] = 8'h00;
    m_ptr = 0; m_rx = 1'b0; m_got = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 8; i++) begin
      ahb_rd(32'(i * 4), v);
      chk($sformatf("%s bank[%0d]", tag, i), v, {24'b0, m_bank[i]});
    end
    ahb_rd(32'h40, v);
    chk({tag, " status"}, v, {30'b0, m_rx, 1'b0});
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    m_sda = b; tick(q);
    scl = 1'b1; tick(2 * q);
    r = sda;
    scl = 1'b0; tick(q);
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; tick(q);
    scl = 1'b1; tick(q);
    m_sda = 1'b0; tick(q);
    scl = 1'b0; tick(q);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; tick(q);
    scl = 1'b1; tick(q);
    m_sda = 1'b1; tick(q + 4);
    m_rx = m_rx | m_got; m_got = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
    i2c_bit(1'b1, a);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, r);
      b[i] = r;
    end
    i2c_bit(nack, r);
    chk("master ack bit on line", 32'(r), 32'(nack));
  endtask

  // write transaction without the STOP: pointer byte then n data bytes from tx[]
  task automatic i2c_write(input logic [7:0] ptr, input int n);
    logic a;
    i2c_start;
    send_byte(8'h84, a); chk("wr addr ack", 32'(a), 32'd0);
    send_byte(ptr, a); chk("wr ptr ack", 32'(a), 32'd0);
    m_ptr = int'(ptr) % 8;
    for (int i = 0; i < n; i++) begin
      send_byte(tx[i], a); chk("wr data ack", 32'(a), 32'd0);
      m_bank[m_ptr] = tx[i];
      m_ptr = (m_ptr + 1) % 8;
      m_got = 1'b1;
    end
  endtask

  // read transaction without the STOP: n bytes, last one NACKed
  task automatic i2c_read(input int n);
    logic a;
    logic [7:0] b;
    i2c_start;
    send_byte(8'h85, a); chk("rd addr ack", 32'(a), 32'd0);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, b);
      chk($sformatf("rd byte %0d", i), {24'b0, b}, {24'b0, m_bank[m_ptr]});
      m_ptr = (m_ptr + 1) % 8;
    end
  endtask

  initial begin
    logic r;
    model_reset;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("reset sda released", 32'(sda), 32'd1);
    chk("hreadyout", 32'(hreadyout), 32'd1);
    chk("hresp", 32'(hresp), 32'd0);
    check_regs("reset");

    // 1: basic write, status set and W1C
    q = 2;
    tx[0] = 8'hA5; tx[1] = 8'h5A;
    i2c_write(8'h03, 2);
    ahb_rd(32'h40, d); chk("busy mid write", d, 32'h1);
    i2c_stop;
    ahb_rd(32'h0C, d); chk("s1 bank[3]", d, 32'hA5);
    ahb_rd(32'h40, d); chk("s1 status", d, 32'h2);
    ahb_wr(32'h40, 32'h1);
    ahb_rd(32'h40, d); chk("status bit0 write ignored", d, 32'h2);
    ahb_wr(32'h40, 32'h2); m_rx = 1'b0;
    ahb_rd(32'h40, d); chk("s1 status cleared", d, 32'h0);
    check_regs("s1");

    // 2: wrong address is not acknowledged
    q = 3;
    i2c_start;
    send_byte(8'h86, ack); chk("s2 no ack", 32'(ack), 32'd1);
    ahb_rd(32'h40, d); chk("s2 not busy", d, 32'h0);
    send_byte(8'h01, ack); chk("s2 ignored byte", 32'(ack), 32'd1);
    i2c_stop;
    check_regs("s2");

    // 3: pointer write, repeated START, read with wrap
    q = 4;
    ahb_wr(32'h1C, 32'h3C); m_bank[7] = 8'h3C;
    ahb_wr(32'h00, 32'h9E); m_bank[0] = 8'h9E;
    i2c_write(8'h07, 0);
    i2c_read(2);
    ahb_rd(32'h40, d); chk("s3 idle after nack", d, 32'h0);
    i2c_stop;
    check_regs("s3");

    // 4: write wrap across the top of the bank
    q = 2;
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
    i2c_write(8'h07, 3);
    i2c_stop;
    check_regs("s4");

    // 5: STOP inside a data byte discards it
    q = 3;
    tx[0] = 8'h6D;
    i2c_write(8'h02, 1);
    for (int i = 0; i < 4; i++) i2c_bit(1'b0, r);
    i2c_stop;
    check_regs("s5a");
    ahb_wr(32'h40, 32'h2); m_rx = 1'b0;
    i2c_write(8'h05, 0);
    for (int i = 0; i < 4; i++) i2c_bit(1'b1, r);
    i2c_stop;
    check_regs("s5b");

    // unmapped space
    ahb_wr(32'h44, 32'hFF);
    ahb_rd(32'h44, d); chk("unmapped 0x44", d, 32'h0);
    ahb_rd(32'h20, d); chk("unmapped 0x20", d, 32'h0);

    // random traffic against the model
    for (int t = 0; t < 40; t++) begin
      q = int'($urandom_range(2, 4));
      case ($urandom_range(0, 4))
        0: begin
          for (int i = 0; i < 4; i++) tx[i] = 8'($urandom);
          i2c_write(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
          i2c_stop;
        end
        1: begin
          i2c_read(int'($urandom_range(1, 3)));
          i2c_stop;
        end
        2: begin
          int idx = int'($urandom_range(0, 7));
          d = $urandom;
          ahb_wr(32'(idx * 4), d);
          m_bank[idx] = d[7:0];
        end
        3: begin
          d = $urandom;
          ahb_wr(32'h40, d);
          if (d[1]) m_rx = 1'b0;
        end
        default: begin
          i2c_write(8'($urandom_range(0, 255)), 0);
          i2c_read(int'($urandom_range(1, 3)));
          i2c_stop;
        end
      endcase
      check_regs($sformatf("rnd%0d", t));
    end

    // 6: reset while the target drives a 0 data bit
    q = 2;
    ahb_wr(32'(m_ptr * 4), 32'h3F); m_bank[m_ptr] = 8'h3F;
    i2c_start;
    send_byte(8'h85, ack); chk("s6 addr ack", 32'(ack), 32'd0);
    tick(2);
    chk("s6 driving bit7=0", 32'(sda), 32'd0);
    rst = 1'b1;
    tick(1);
    chk("s6 sda released after reset", 32'(sda), 32'd1);
    rst = 1'b0;
    model_reset;
    i2c_stop;
    check_regs("s6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
